// File: rtl/page_queue_manager_if.sv
// Handshake/bus bundle for page_queue_manager: enqueue grant, dequeue
// request/response, page free and status outputs. Clock and reset stay
// plain ports on the module.
interface page_queue_manager_if #(
  parameter int NUM_PORTS = 16,
  parameter int NUM_PRIOR = 8,
  parameter int PAGES     = 2048
);
  localparam int PRW   = $clog2(NUM_PORTS);
  localparam int PRI_W = $clog2(NUM_PRIOR);
  localparam int PW    = $clog2(PAGES);

  logic                           enq_vld;
  logic [PRW-1:0]                 enq_port;
  logic [PRI_W-1:0]               enq_prior;
  logic                           enq_ready;
  logic [PW-1:0]                  enq_page;

  logic                           deq_vld;
  logic [PRW-1:0]                 deq_port;
  logic                           sched_mode;
  logic                           deq_done;
  logic [PW-1:0]                  deq_page;
  logic [PRI_W-1:0]               deq_prior;

  logic                           free_vld;
  logic [PW-1:0]                  free_page;

  logic [NUM_PORTS*NUM_PRIOR-1:0] queue_nonempty;
  logic [PW:0]                    free_cnt;

  // Requester side (write distribution / port readers)
  modport master (
    output enq_vld, enq_port, enq_prior,
    output deq_vld, deq_port, sched_mode,
    output free_vld, free_page,
    input  enq_ready, enq_page,
    input  deq_done, deq_page, deq_prior,
    input  queue_nonempty, free_cnt
  );

  // Queue manager side
  modport slave (
    input  enq_vld, enq_port, enq_prior,
    input  deq_vld, deq_port, sched_mode,
    input  free_vld, free_page,
    output enq_ready, enq_page,
    output deq_done, deq_page, deq_prior,
    output queue_nonempty, free_cnt
  );
endinterface

// File: rtl/page_queue_manager.sv
// Linked-list page queue manager for the shared packet buffer.
// Pages come from a recycled free list first, then from a bump allocator.
// Each (port, priority) queue is a singly linked list threaded through
// next_mem; dequeue selects a priority by strict order or by WRR credits.
module page_queue_manager #(
  parameter int NUM_PORTS = 16,
  parameter int NUM_PRIOR = 8,
  parameter int PAGES     = 2048
) (
  input  logic                clk,
  input  logic                rst,
  page_queue_manager_if.slave bus
);
  localparam int PRW   = $clog2(NUM_PORTS);
  localparam int PRI_W = $clog2(NUM_PRIOR);
  localparam int PW    = $clog2(PAGES);
  localparam int CNTW  = PW + 1;
  localparam int CW    = $clog2(NUM_PRIOR + 1);

  // Link table: one successor pointer per page
  logic [PW-1:0]    next_mem [PAGES];

  // Allocator state
  logic [CNTW-1:0]  fresh_ptr_reg, fresh_ptr_next;
  logic [CNTW-1:0]  rec_cnt_reg, rec_cnt_next;
  logic [PW-1:0]    rec_head_reg, rec_tail_reg;
  logic [CNTW-1:0]  free_cnt_reg;

  // Dequeue response registers
  logic             deq_done_reg;
  logic [PW-1:0]    deq_page_reg;
  logic [PRI_W-1:0] deq_prior_reg;

  // Per-queue views collected from the generate blocks
  logic [PW-1:0]    head_mat [NUM_PORTS][NUM_PRIOR];
  logic [PW-1:0]    tail_mat [NUM_PORTS][NUM_PRIOR];
  logic             ne_mat   [NUM_PORTS][NUM_PRIOR];
  logic             cr_mat   [NUM_PORTS][NUM_PRIOR];
  logic [NUM_PORTS*NUM_PRIOR-1:0] qne_vec;

  // Allocation
  logic             alloc_rec, enq_ready, grant, grant_rec, grant_fresh;
  logic [PW-1:0]    enq_page;
  logic             enq_link, free_link;
  logic [PW-1:0]    enq_tail;

  // Dequeue selection
  logic [NUM_PRIOR-1:0] port_ne, port_cr;
  logic [PRI_W-1:0] strict_sel, wrr_sel, deq_sel;
  logic             wrr_hit, deq_fire, wrr_reload;
  logic [PW-1:0]    deq_head, deq_next_head;

  assign alloc_rec   = rec_cnt_reg != '0;
  assign enq_ready   = alloc_rec || (fresh_ptr_reg < CNTW'(PAGES));
  assign enq_page    = alloc_rec ? rec_head_reg : fresh_ptr_reg[PW-1:0];
  assign grant       = bus.enq_vld && enq_ready;
  assign grant_rec   = grant && alloc_rec;
  assign grant_fresh = grant && !alloc_rec;

  assign enq_tail    = tail_mat[bus.enq_port][bus.enq_prior];
  assign enq_link    = grant && ne_mat[bus.enq_port][bus.enq_prior];
  // When the last recycled page is granted while another is freed, the
  // freed page becomes the whole list, so no link is needed.
  assign free_link   = bus.free_vld && alloc_rec &&
                       !(grant_rec && rec_cnt_reg == CNTW'(1));

  assign rec_cnt_next   = rec_cnt_reg + CNTW'(bus.free_vld) - CNTW'(grant_rec);
  assign fresh_ptr_next = fresh_ptr_reg + CNTW'(grant_fresh);

  assign deq_head      = head_mat[bus.deq_port][deq_sel];
  assign deq_next_head = next_mem[deq_head];

  assign bus.enq_ready      = enq_ready;
  assign bus.enq_page       = enq_page;
  assign bus.deq_done       = deq_done_reg;
  assign bus.deq_page       = deq_page_reg;
  assign bus.deq_prior      = deq_prior_reg;
  assign bus.queue_nonempty = qne_vec;
  assign bus.free_cnt       = free_cnt_reg;

  // Pick the priority to serve on deq_port (lowest index wins)
  always_comb begin
    port_ne    = '0;
    port_cr    = '0;
    strict_sel = '0;
    wrr_sel    = '0;
    wrr_hit    = 1'b0;
    for (int p = 0; p < NUM_PRIOR; p++) begin
      port_ne[p] = ne_mat[bus.deq_port][p];
      port_cr[p] = cr_mat[bus.deq_port][p];
    end
    for (int p = NUM_PRIOR - 1; p >= 0; p--) begin
      if (port_ne[p]) strict_sel = PRI_W'(p);
      if (port_ne[p] && port_cr[p]) begin
        wrr_sel = PRI_W'(p);
        wrr_hit = 1'b1;
      end
    end
    deq_fire   = bus.deq_vld && (port_ne != '0);
    wrr_reload = deq_fire && bus.sched_mode && !wrr_hit;
    deq_sel    = (bus.sched_mode && wrr_hit) ? wrr_sel : strict_sel;
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    for (genvar gr = 0; gr < NUM_PRIOR; gr++) begin : g_prior
      localparam logic [CW-1:0] WEIGHT = CW'(NUM_PRIOR - gr);
      logic [PW-1:0]   head_reg, tail_reg;
      logic [CNTW-1:0] cnt_reg, cnt_next;
      logic [CW-1:0]   credit_reg;
      logic            qne_reg, enq_hit, deq_hit, port_hit;

      assign enq_hit  = grant && bus.enq_port == PRW'(gp) && bus.enq_prior == PRI_W'(gr);
      assign port_hit = deq_fire && bus.deq_port == PRW'(gp);
      assign deq_hit  = port_hit && deq_sel == PRI_W'(gr);
      assign cnt_next = cnt_reg + CNTW'(enq_hit) - CNTW'(deq_hit);

      assign head_mat[gp][gr] = head_reg;
      assign tail_mat[gp][gr] = tail_reg;
      assign ne_mat[gp][gr]   = cnt_reg != '0;
      assign cr_mat[gp][gr]   = credit_reg != '0;
      assign qne_vec[gp*NUM_PRIOR+gr] = qne_reg;

      // Queue pointers, occupancy and WRR credit for this (port, priority)
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg    <= '0;
          qne_reg    <= 1'b0;
          credit_reg <= WEIGHT;
        end else begin
          cnt_reg <= cnt_next;
          qne_reg <= cnt_next != '0;
          if (enq_hit) tail_reg <= enq_page;
          // A new page becomes head if the list is, or is about to be, empty
          if (enq_hit && (cnt_reg == '0 || (deq_hit && cnt_reg == CNTW'(1))))
            head_reg <= enq_page;
          else if (deq_hit)
            head_reg <= deq_next_head;
          if (port_hit && bus.sched_mode) begin
            if (wrr_reload)
              credit_reg <= deq_hit ? WEIGHT - CW'(1) : WEIGHT;
            else if (deq_hit)
              credit_reg <= credit_reg - CW'(1);
          end
        end
      end
    end
  end

  // Link table writes: queue append and free-list append (distinct pages)
  always_ff @(posedge clk) begin
    if (enq_link)  next_mem[enq_tail]     <= enq_page;
    if (free_link) next_mem[rec_tail_reg] <= bus.free_page;
  end

  // Bump allocator, recycled free list and free page count
  always_ff @(posedge clk) begin
    if (rst) begin
      fresh_ptr_reg <= '0;
      rec_cnt_reg   <= '0;
      free_cnt_reg  <= CNTW'(PAGES);
    end else begin
      fresh_ptr_reg <= fresh_ptr_next;
      rec_cnt_reg   <= rec_cnt_next;
      free_cnt_reg  <= rec_cnt_next + CNTW'(PAGES) - fresh_ptr_next;
      if (grant_rec) rec_head_reg <= next_mem[rec_head_reg];
      if (bus.free_vld) begin
        rec_tail_reg <= bus.free_page;
        if (!alloc_rec || (grant_rec && rec_cnt_reg == CNTW'(1)))
          rec_head_reg <= bus.free_page;
      end
    end
  end

  // Registered dequeue response, valid one cycle after the request
  always_ff @(posedge clk) begin
    if (rst) begin
      deq_done_reg  <= 1'b0;
      deq_page_reg  <= '0;
      deq_prior_reg <= '0;
    end else begin
      deq_done_reg <= deq_fire;
      if (deq_fire) begin
        deq_page_reg  <= deq_head;
        deq_prior_reg <= deq_sel;
      end
    end
  end
endmodule

// File: tb/tb_page_queue_manager.sv
// Directed testbench for page_queue_manager: allocation order, queue FIFO
// order, strict and WRR scheduling, same-cycle corner cases and reset.
module tb_page_queue_manager;
  localparam int NUM_PORTS = 16;
  localparam int NUM_PRIOR = 8;
  localparam int PAGES     = 2048;
  localparam int PRW       = $clog2(NUM_PORTS);
  localparam int PRI_W     = $clog2(NUM_PRIOR);
  localparam int PW        = $clog2(PAGES);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  page_queue_manager_if #(.NUM_PORTS(NUM_PORTS), .NUM_PRIOR(NUM_PRIOR), .PAGES(PAGES)) bus ();

  page_queue_manager #(.NUM_PORTS(NUM_PORTS), .NUM_PRIOR(NUM_PRIOR), .PAGES(PAGES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_enq(input int port, input int prio, input int exp_page, input string tag);
    bus.enq_vld   = 1'b1;
    bus.enq_port  = PRW'(port);
    bus.enq_prior = PRI_W'(prio);
    check(tag, bus.enq_page, exp_page);
    tick();
    bus.enq_vld = 1'b0;
  endtask

  task automatic do_deq(input int port, input int mode, input int exp_page, input int exp_prior,
                        input string tag);
    bus.deq_vld    = 1'b1;
    bus.deq_port   = PRW'(port);
    bus.sched_mode = mode[0];
    tick();
    bus.deq_vld = 1'b0;
    check({tag, "_done"}, bus.deq_done, 1);
    check({tag, "_page"}, bus.deq_page, exp_page);
    check({tag, "_prior"}, bus.deq_prior, exp_prior);
  endtask

  task automatic do_free(input int page);
    bus.free_vld  = 1'b1;
    bus.free_page = PW'(page);
    tick();
    bus.free_vld = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rec_order[3];
    int p0, p7;
    rec_order = '{2, 0, 1};
    rst = 1'b1;
    bus.enq_vld = 1'b0; bus.enq_port = '0; bus.enq_prior = '0;
    bus.deq_vld = 1'b0; bus.deq_port = '0; bus.sched_mode = 1'b0;
    bus.free_vld = 1'b0; bus.free_page = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_deq_done", bus.deq_done, 0);
    check("rst_deq_page", bus.deq_page, 0);
    check("rst_deq_prior", bus.deq_prior, 0);
    check("rst_qne", bus.queue_nonempty, 0);
    check("rst_free_cnt", bus.free_cnt, PAGES);
    check("rst_enq_ready", bus.enq_ready, 1);
    check("rst_enq_page", bus.enq_page, 0);

    // Three enqueues to (2,5), then drain them in order
    do_enq(2, 5, 0, "enq25_a");
    do_enq(2, 5, 1, "enq25_b");
    do_enq(2, 5, 2, "enq25_c");
    check("qne_bit21_set", bus.queue_nonempty[21], 1);
    check("free_cnt_3used", bus.free_cnt, PAGES - 3);
    do_deq(2, 0, 0, 5, "deq25_a");
    do_deq(2, 0, 1, 5, "deq25_b");
    do_deq(2, 0, 2, 5, "deq25_c");
    check("qne_bit21_clr", bus.queue_nonempty[21], 0);
    tick();
    check("deq_done_idle", bus.deq_done, 0);

    // Recycled pages are granted first, in free order
    do_free(2);
    do_free(0);
    do_free(1);
    check("free_cnt_refilled", bus.free_cnt, PAGES);
    check("rec_precedence", bus.enq_page, 2);

    // Fill every page across many queues
    for (int i = 0; i < PAGES; i++)
      do_enq(i % NUM_PORTS, (i / NUM_PORTS) % NUM_PRIOR, (i < 3) ? rec_order[i] : i, "fill_page");
    check("full_enq_ready", bus.enq_ready, 0);
    check("full_free_cnt", bus.free_cnt, 0);
    bus.enq_vld = 1'b1;
    tick();
    bus.enq_vld = 1'b0;
    check("full_ignored_cnt", bus.free_cnt, 0);
    check("full_ignored_ready", bus.enq_ready, 0);
    do_free(7);
    check("free7_ready", bus.enq_ready, 1);
    check("free7_page", bus.enq_page, 7);
    check("free7_cnt", bus.free_cnt, 1);

    // Clean start for scheduling tests
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Strict priority: prio 1 drains before prio 6 on port 0
    do_enq(0, 6, 0, "strict_enq6a");
    do_enq(0, 6, 1, "strict_enq6b");
    do_enq(0, 1, 2, "strict_enq1a");
    do_enq(0, 1, 3, "strict_enq1b");
    check("strict_qne", bus.queue_nonempty, 128'h42);
    do_deq(0, 0, 2, 1, "strict_d0");
    do_deq(0, 0, 3, 1, "strict_d1");
    do_deq(0, 0, 0, 6, "strict_d2");
    do_deq(0, 0, 1, 6, "strict_d3");

    // WRR on port 3: prio 0 x8 then prio 7 x1, reload, repeat
    for (int i = 0; i < 20; i++) do_enq(3, 0, 4 + i, "wrr_enq0");
    for (int i = 0; i < 20; i++) do_enq(3, 7, 24 + i, "wrr_enq7");
    p0 = 4;
    p7 = 24;
    for (int k = 0; k < 18; k++) begin
      if (k % 9 < 8) begin
        do_deq(3, 1, p0, 0, "wrr");
        p0++;
      end else begin
        do_deq(3, 1, p7, 7, "wrr");
        p7++;
      end
    end

    // Same-cycle enqueue and dequeue on a single-entry queue (5,2)
    do_enq(5, 2, 44, "same_enq_first");
    bus.enq_vld = 1'b1; bus.enq_port = PRW'(5); bus.enq_prior = PRI_W'(2);
    bus.deq_vld = 1'b1; bus.deq_port = PRW'(5); bus.sched_mode = 1'b0;
    check("same_enq_page", bus.enq_page, 45);
    tick();
    bus.enq_vld = 1'b0; bus.deq_vld = 1'b0;
    check("same_deq_done", bus.deq_done, 1);
    check("same_deq_page", bus.deq_page, 44);
    check("same_deq_prior", bus.deq_prior, 2);
    check("same_qne42", bus.queue_nonempty[42], 1);
    do_deq(5, 0, 45, 2, "same_next");
    check("same_qne42_clr", bus.queue_nonempty[42], 0);

    // Same-cycle allocation and free with one recycled page
    do_free(44);
    check("af_cnt_before", bus.free_cnt, 2003);
    bus.enq_vld = 1'b1; bus.enq_port = PRW'(6); bus.enq_prior = PRI_W'(0);
    bus.free_vld = 1'b1; bus.free_page = PW'(45);
    check("af_grant", bus.enq_page, 44);
    tick();
    bus.enq_vld = 1'b0; bus.free_vld = 1'b0;
    check("af_cnt_after", bus.free_cnt, 2003);
    check("af_new_head", bus.enq_page, 45);
    do_enq(6, 0, 45, "af_enq_rec");
    check("af_cnt_drained", bus.free_cnt, 2002);
    check("af_fresh_next", bus.enq_page, 46);
    do_deq(6, 0, 44, 0, "af_deq_a");
    do_deq(6, 0, 45, 0, "af_deq_b");

    // Allocation and free with an empty recycled list: no bypass
    bus.enq_vld = 1'b1; bus.enq_port = PRW'(6); bus.enq_prior = PRI_W'(1);
    bus.free_vld = 1'b1; bus.free_page = PW'(44);
    check("nobypass_grant", bus.enq_page, 46);
    tick();
    bus.enq_vld = 1'b0; bus.free_vld = 1'b0;
    check("nobypass_rec", bus.enq_page, 44);
    check("nobypass_cnt", bus.free_cnt, 2002);

    // Dequeue on a port with no pages does nothing
    bus.deq_vld = 1'b1; bus.deq_port = PRW'(9);
    tick();
    bus.deq_vld = 1'b0;
    check("empty_port_deq", bus.deq_done, 0);

    // Reset in the middle of traffic
    bus.enq_vld = 1'b1; bus.enq_port = PRW'(2); bus.enq_prior = PRI_W'(5);
    bus.deq_vld = 1'b1; bus.deq_port = PRW'(3); bus.sched_mode = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.enq_vld = 1'b0; bus.deq_vld = 1'b0;
    check("mid_rst_deq_done", bus.deq_done, 0);
    check("mid_rst_qne", bus.queue_nonempty, 0);
    check("mid_rst_free_cnt", bus.free_cnt, PAGES);
    check("mid_rst_enq_page", bus.enq_page, 0);
    check("mid_rst_enq_ready", bus.enq_ready, 1);
    do_enq(2, 5, 0, "post_rst_enq");
    do_deq(2, 0, 0, 5, "post_rst_deq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/page_queue_manager.md
# page_queue_manager

Parametrised linked-list queue manager for the shared packet buffer. It allocates pages, keeps NUM_PORTS×NUM_PRIOR per-(destination port, priority) page queues as linked lists in a next-pointer table, and hands pages back on dequeue. Dequeue can run in strict-priority mode or weighted-round-robin (WRR) mode. It sits between the write-side distribution logic, which enqueues, and the read-side per-port readers, which dequeue and later free pages.

## Interface
Parameters:
- NUM_PORTS, 16: destination ports; PRW = clog2(NUM_PORTS).
- NUM_PRIOR, 8: priorities per port, 0 is highest; PRI_W = clog2(NUM_PRIOR).
- PAGES, 2048: pages in the buffer; PW = clog2(PAGES).

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  synchronous, active-high reset.
- enq_vld  in  1  enqueue request.
- enq_port  in  PRW  destination port of the enqueue.
- enq_prior  in  PRI_W  priority of the enqueue.
- enq_ready  out  1  a free page exists (combinational).
- enq_page  out  PW  page that is granted when enq_vld&&enq_ready (combinational).
- deq_vld  in  1  dequeue request.
- deq_port  in  PRW  port to dequeue from.
- sched_mode  in  1  0 = strict priority, 1 = WRR; sampled per request.
- deq_done  out  1  registered pulse: a page was dequeued.
- deq_page  out  PW  dequeued page; valid with deq_done.
- deq_prior  out  PRI_W  priority it came from; valid with deq_done.
- free_vld  in  1  return a page to the free pool.
- free_page  in  PW  page being returned.
- queue_nonempty  out  NUM_PORTS*NUM_PRIOR  bit port*NUM_PRIOR+prior, registered.
- free_cnt  out  PW+1  free pages, registered.

## Operation
- State:
  - next[PAGES] (PW bits), a register array, 2 write ports and 2 read ports.
  - Per queue: head, tail (PW bits) and cnt (PW+1 bits).
  - fresh_ptr (PW+1 bits), the bump allocator for never-used pages.
  - Recycled free list: rec_head, rec_tail, rec_cnt.
  - credit[port][prior] (clog2(NUM_PRIOR+1) bits).
- Allocation:
  - enq_ready = rec_cnt>0 || fresh_ptr<PAGES.
  - enq_page = rec_cnt>0 ? rec_head : fresh_ptr[PW-1:0].
  - Recycled pages take precedence.
  - On grant: if recycled, rec_head<=next[rec_head] and rec_cnt-1; else fresh_ptr+1.
  - enq_vld with enq_ready=0 is ignored.
- Enqueue to queue q:
  - If cnt==0: head<=page, tail<=page.
  - Otherwise: next[tail]<=page, tail<=page.
  - In both cases cnt+1.
- Free:
  - If rec_cnt==0: rec_head<=free_page, rec_tail<=free_page.
  - Otherwise: next[rec_tail]<=free_page, rec_tail<=free_page.
  - In both cases rec_cnt+1.
  - A double free, or freeing a page that was never allocated, is undefined.
- Dequeue on port p:
  - Strict mode: pick the lowest-index nonempty priority.
  - WRR mode: pick the lowest-index nonempty priority with credit>0, then decrement that credit.
  - WRR reload: if no nonempty priority has credit, reload every credit of p to weight w=NUM_PRIOR-prior, then pick strictly and decrement.
  - Strict mode leaves credits unchanged.
  - Selected queue: deq_page<=head, head<=next[head], cnt-1.
  - If all queues of p are empty: no-op, and deq_done stays 0.
- Simultaneous events, all within the same cycle:
  - Enqueue and dequeue on the same queue with cnt==1: head and tail both become the new page; cnt stays 1.
  - Allocation and free with rec_cnt==1: rec_head and rec_tail both become free_page.
  - Allocation and free with rec_cnt==0: allocate from fresh_ptr. A freed page is never bypassed into the same-cycle grant.
  - The enqueue link write and the free link write always target distinct pages.
- free_cnt <= rec_cnt' + PAGES - fresh_ptr', using the next-state values.

## Timing
- Enqueue and free take effect at the accepting posedge.
- Dequeue is requested in cycle N; deq_done, deq_page and deq_prior are valid in N+1 for one cycle.
- queue_nonempty and free_cnt reflect state after the latest edge, with a 1-cycle lag from the request.
- Back-to-back dequeues on the same queue are legal every cycle, because the head update is in the same edge.
- Reset values:
  - deq_done=0, deq_page=0, deq_prior=0.
  - queue_nonempty=0, free_cnt=PAGES.
  - All cnt=0, rec_cnt=0, fresh_ptr=0.
  - Credits = weights.
  - enq_ready=1, enq_page=0 in the first cycle after reset.
- Reset mid-operation drops all queues and frees every page. The next[] contents need no clearing.

## Test plan
- Reset, then 3 enqueues to (port 2, prio 5): pages 0,1,2 granted. queue_nonempty bit 21=1, free_cnt=PAGES-3. Three dequeues on port 2 return 0,1,2 with deq_prior=5; the bit then clears.
- Fill all PAGES, spread across queues: enq_ready=0 after the last grant and free_cnt=0. Free page 7: enq_ready=1 and enq_page=7.
- Strict mode with port 0 having prio 1 and prio 6 nonempty: repeated dequeues drain prio 1 first.
- WRR mode with port 3 holding 20 pages in each of prio 0 and prio 7: the first 9 dequeues give prio 0 ×8 then prio 7 ×1. A reload follows, and the sequence repeats.
- Same-cycle enqueue and dequeue on a cnt==1 queue: deq_page = the old head, and the next dequeue returns the new page. Also same-cycle alloc and free with rec_cnt==1: the list stays consistent and free_cnt is unchanged.
- Assert rst mid-traffic: the next cycle shows deq_done=0, queue_nonempty=0, free_cnt=PAGES, and enq_page=0.
